flag_status_table: RTL
======================

Name: flag_status_table

Overview:
- Parametrised rename-status table for condition flags in the Tomasulo core.
- Tracks NUM_CH independent flag channels, e.g. ch0 = NZ group, ch1 = CV group.
- Per channel it records whether a ROB entry will produce the flags, and which one. It snoops NUM_CDB result buses and captures the broadcast flag value when the matching tag completes.
- Sits beside the register status table; dispatch reads it to tag flag-consuming instructions, and writes it when a flag-setting instruction is appended.

Parameters:
- TAG_W, 3, ROB tag width (ROB depth = 2**TAG_W)
- NUM_CH, 2, number of independent flag channels
- FLAG_W, 4, flag value bits held per channel
- NUM_CDB, 2, number of common data bus ports snooped per cycle

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- append  in  1  dispatch appends an instruction this cycle
- set_mask  in  NUM_CH  channels written by the appended instruction (ignored unless append)
- rob_tail  in  TAG_W  ROB tag allocated to the appended instruction
- flush  in  1  mispredict/exception recovery; drops all outstanding producers
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  per-port ROB tag, port p at [p*TAG_W +: TAG_W]
- cdb_flags  in  NUM_CDB*FLAG_W  per-port flag result, port p at [p*FLAG_W +: FLAG_W]
- ready  out  NUM_CH  registered: channel has no outstanding producer
- tag  out  NUM_CH*TAG_W  registered: producer tag per channel (meaningful when ready=0)
- value  out  NUM_CH*FLAG_W  registered: last captured flag value per channel
- fwd_ready  out  NUM_CH  combinational: ready OR a CDB port matches tag this cycle
- fwd_value  out  NUM_CH*FLAG_W  combinational: matching CDB flags if a CDB port matches, else value

Behaviour:
- Reset (async, any time, including mid-operation):
  - ready = all 1s, tag = 0, value = 0.
  - All pending producers are lost.
- Per-channel state: busy (= ~ready), tag[TAG_W], value[FLAG_W]. All updates occur on the rising edge of CLK.
- Priority per channel c, evaluated each cycle, highest first:
  1. flush=1 -> ready<=1, tag held, value held. Flush overrides append and CDB in the same cycle.
  2. append=1 and set_mask[c]=1 -> ready<=0, tag<=rob_tail.
     - A CDB match on the old tag in the same cycle does NOT update value; the new producer supersedes it.
  3. ready=0 and a CDB match -> ready<=1, value<=cdb_flags of the matching port.
     - CDB match for port p: cdb_valid[p]=1 and cdb_tag[p]==tag[c].
  4. Otherwise hold.
- Multiple CDB ports matching the same tag (illegal upstream): the lowest port index wins; no error output.
- CDB match while ready=1: ignored. A stale tag must not alter value.
- Re-append to a busy channel: tag overwritten with the newest rob_tail; the older producer's broadcast is then ignored.
- Tag comparison is exact TAG_W-bit equality. ROB wrap-around aliasing is prevented by the ROB, which never reuses a tag while it is outstanding.
- Forward outputs:
  - Purely combinational from the current state and CDB inputs.
  - Not affected by same-cycle append or flush.
  - Dispatch uses them so an instruction dispatched in the broadcast cycle does not wait a cycle.
- Latency:
  - append -> ready=0 visible the next cycle.
  - CDB -> ready=1 and value visible the next cycle; fwd_* reflect it in the same cycle.
- Channels are fully independent. set_mask=0 with append=1 changes nothing.

Decomposition:
- Shared package:
  - TAG_W default
  - flag channel indices (CH_NZ=0, CH_CV=1)
  - flag bit positions within FLAG_W (N=3, Z=2, C=1, V=0)
  - CDB field offsets, so they stay consistent with the register status table
- Sub-module flag_status_channel:
  - one channel's busy/tag/value state, CDB match logic and forward mux
  - generate-instantiated NUM_CH times
  - parametrised by TAG_W, FLAG_W, NUM_CDB

Test Plan:
- Reset check: assert Reset mid-sequence with ch0 busy -> ready=2'b11, tag=0, value=0 immediately; no CLK needed.
- Append then broadcast: append, set_mask=2'b01, rob_tail=5 -> next cycle ready[0]=0, tag0=5. Then CDB port1 valid, tag=5, flags=4'b1010 -> fwd_ready[0]=1 and fwd_value0=1010 in the same cycle; next cycle ready[0]=1, value0=1010.
- Re-append supersedes: ch1 busy on tag 2; append, mask=2'b10, tail=6 in the same cycle as CDB tag=2, flags=4'hF -> ch1 ready=0, tag=6, value unchanged. A later CDB tag=2 is ignored; CDB tag=6, flags=4'h3 -> value1=3.
- Flush priority: ch0 busy on tag 3, ch1 busy on tag 4; flush with append mask=2'b11 and CDB tag=3 -> next cycle ready=2'b11, values unchanged. A subsequent CDB tag=4 leaves value1 unchanged.
- Dual-CDB: ch0 waits tag 1, ch1 waits tag 7; port0 tag=7, flags=4'h8 and port1 tag=1, flags=4'h2 in the same cycle -> value0=2, value1=8, ready=2'b11. With both ports carrying tag=1 (flags 4'h5 and 4'h9) -> port0 wins, value0=5.
- Wrap: append tails 7, then 0 on ch0, then CDB tag=7 -> ignored; CDB tag=0 -> ready[0]=1.

Source files
------------

// File: rtl/flag_status_table_pkg.sv
// Shared definitions for the flag rename-status table: channel indices, flag bit
// positions and CDB field offsets common with the register status table.
package flag_status_table_pkg;

  localparam int FST_TAG_W = 3;

  localparam int CH_NZ = 0;
  localparam int CH_CV = 1;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // CDB port p occupies [p*width +: width] of each packed bus.
  function automatic int cdb_tag_lsb(input int p, input int tag_w);
    return p * tag_w;
  endfunction

  function automatic int cdb_flags_lsb(input int p, input int flag_w);
    return p * flag_w;
  endfunction

endpackage

// File: rtl/flag_status_table_channel.sv
// One flag channel: producer busy/tag/value state, CDB snoop and same-cycle forward.
module flag_status_channel
  import flag_status_table_pkg::*;
#(
  parameter int TAG_W   = FST_TAG_W,
  parameter int FLAG_W  = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      append,
  input  logic                      set,
  input  logic [TAG_W-1:0]          rob_tail,
  input  logic                      flush,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*FLAG_W-1:0] cdb_flags,
  output logic                      ready,
  output logic [TAG_W-1:0]          tag,
  output logic [FLAG_W-1:0]         value,
  output logic                      fwd_ready,
  output logic [FLAG_W-1:0]         fwd_value
);

  logic              hit;
  logic [FLAG_W-1:0] hit_flags;

  // Scan from the highest port down so the lowest matching port wins. Only a
  // busy channel can match; a stale tag on a ready channel is ignored.
  always_comb begin
    hit       = 1'b0;
    hit_flags = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (!ready && cdb_valid[p] &&
          cdb_tag[cdb_tag_lsb(p, TAG_W) +: TAG_W] == tag) begin
        hit       = 1'b1;
        hit_flags = cdb_flags[cdb_flags_lsb(p, FLAG_W) +: FLAG_W];
      end
    end
  end

  assign fwd_ready = ready | hit;
  assign fwd_value = hit ? hit_flags : value;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ready <= 1'b1;
      tag   <= '0;
      value <= '0;
    end else if (flush) begin
      ready <= 1'b1;
    end else if (append && set) begin
      // The new producer supersedes any broadcast of the old tag this cycle.
      ready <= 1'b0;
      tag   <= rob_tail;
    end else if (hit) begin
      ready <= 1'b1;
      value <= hit_flags;
    end
  end

endmodule

// File: rtl/flag_status_table.sv
// Rename-status table for condition flags: NUM_CH independent channels, each
// tracking its pending ROB producer and capturing the flag value from the CDB.
module flag_status_table
  import flag_status_table_pkg::*;
#(
  parameter int TAG_W   = FST_TAG_W,
  parameter int NUM_CH  = 2,
  parameter int FLAG_W  = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      append,
  input  logic [NUM_CH-1:0]         set_mask,
  input  logic [TAG_W-1:0]          rob_tail,
  input  logic                      flush,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*FLAG_W-1:0] cdb_flags,
  output logic [NUM_CH-1:0]         ready,
  output logic [NUM_CH*TAG_W-1:0]   tag,
  output logic [NUM_CH*FLAG_W-1:0]  value,
  output logic [NUM_CH-1:0]         fwd_ready,
  output logic [NUM_CH*FLAG_W-1:0]  fwd_value
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    flag_status_channel #(
      .TAG_W  (TAG_W),
      .FLAG_W (FLAG_W),
      .NUM_CDB(NUM_CDB)
    ) u_ch (
      .CLK      (CLK),
      .Reset    (Reset),
      .append   (append),
      .set      (set_mask[c]),
      .rob_tail (rob_tail),
      .flush    (flush),
      .cdb_valid(cdb_valid),
      .cdb_tag  (cdb_tag),
      .cdb_flags(cdb_flags),
      .ready    (ready[c]),
      .tag      (tag[c*TAG_W +: TAG_W]),
      .value    (value[c*FLAG_W +: FLAG_W]),
      .fwd_ready(fwd_ready[c]),
      .fwd_value(fwd_value[c*FLAG_W +: FLAG_W])
    );
  end

endmodule
